// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl
//   Four-channel PWM sequencer. A shared period counter runs 0..period_max and
//   each channel drives out[i] high while cnt < active[i]. Duty writes land in
//   a per-channel shadow register and are committed only at period boundaries
//   (or on any cycle while idle), either as a step or as a +/-1-per-period ramp.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   en           run request (level)
//   period_max   last counter value; period is period_max+1 cycles
//   wr_valid     duty write request
//   wr_ready     write accepted when wr_valid && wr_ready (shadow of wr_chan empty)
//   wr_chan      target channel
//   wr_duty      new duty in high cycles per period
//   wr_ramp      1 = ramp toward wr_duty, 0 = step
//   out          PWM outputs (registered)
//   period_start one-cycle pulse on the first cycle of each period (registered)
//   busy         some channel has active != target (registered)
module pwm_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] period_max,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_chan,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             wr_ramp,
    output logic [3:0]       out,
    output logic             period_start,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state, state_nxt;
    logic [WIDTH-1:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0]       pmax, pmax_nxt;

    logic [3:0]             pend_vld, pend_vld_nxt;
    logic [3:0]             pend_ramp, pend_ramp_nxt;
    logic [3:0][WIDTH-1:0]  pend_duty, pend_duty_nxt;
    logic [3:0]             ramp, ramp_nxt;
    logic [3:0][WIDTH-1:0]  target, target_nxt;
    logic [3:0][WIDTH-1:0]  active, active_nxt;

    logic [3:0]             out_nxt;
    logic                   ps_nxt;
    logic                   busy_nxt;

    logic                   running;
    logic                   boundary;
    logic [WIDTH-1:0]       t_sel;
    logic                   r_sel;

    // One ramp step toward goal, holding once it is reached.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] goal);
        if (cur < goal)
            return cur + 1'b1;
        else if (cur > goal)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    assign wr_ready = ~pend_vld[wr_chan];

    always_comb begin
        running  = (state != ST_IDLE);
        boundary = running && (cnt == pmax);

        state_nxt = state;
        case (state)
            ST_IDLE:          if (en) state_nxt = ST_RUN;
            // DRAIN only differs from RUN in where it goes at the boundary,
            // so both share one transition rule.
            ST_RUN, ST_DRAIN: begin
                if (en)
                    state_nxt = ST_RUN;
                else if (boundary)
                    state_nxt = ST_IDLE;
                else
                    state_nxt = ST_DRAIN;
            end
            default:          state_nxt = ST_IDLE;
        endcase

        cnt_nxt  = (running && !boundary) ? cnt + 1'b1 : '0;
        // Latched continuously while idle so the value seen at IDLE->RUN is kept;
        // while running it only changes at a boundary.
        pmax_nxt = (!running || boundary) ? period_max : pmax;

        pend_vld_nxt  = pend_vld;
        pend_ramp_nxt = pend_ramp;
        pend_duty_nxt = pend_duty;
        ramp_nxt      = ramp;
        target_nxt    = target;
        active_nxt    = active;
        t_sel         = '0;
        r_sel         = 1'b0;

        for (int i = 0; i < 4; i++) begin
            t_sel = pend_vld[i] ? pend_duty[i] : target[i];
            r_sel = pend_vld[i] ? pend_ramp[i] : ramp[i];
            if (!running) begin
                // Idle commits are always steps: nothing is being driven yet.
                if (pend_vld[i]) begin
                    target_nxt[i]   = pend_duty[i];
                    active_nxt[i]   = pend_duty[i];
                    ramp_nxt[i]     = 1'b0;
                    pend_vld_nxt[i] = 1'b0;
                end
            end else if (boundary) begin
                target_nxt[i]   = t_sel;
                ramp_nxt[i]     = r_sel;
                pend_vld_nxt[i] = 1'b0;
                active_nxt[i]   = r_sel ? step_toward(active[i], t_sel) : t_sel;
            end
            // A write can only be accepted into an empty shadow, so it never
            // collides with a commit of the same channel in this cycle.
            if (wr_valid && wr_ready && (wr_chan == 2'(i))) begin
                pend_vld_nxt[i]  = 1'b1;
                pend_duty_nxt[i] = wr_duty;
                pend_ramp_nxt[i] = wr_ramp;
            end
        end

        // Registered outputs are derived from next-state values so they line
        // up with the counter value they describe.
        out_nxt  = '0;
        busy_nxt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_nxt[i] = (state_nxt != ST_IDLE) && (cnt_nxt < active_nxt[i]);
            busy_nxt   = busy_nxt | (active_nxt[i] != target_nxt[i]);
        end
        ps_nxt = (state_nxt != ST_IDLE) && (cnt_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pmax         <= '0;
            pend_vld     <= '0;
            ramp         <= '0;
            target       <= '0;
            active       <= '0;
            out          <= '0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pmax         <= pmax_nxt;
            pend_vld     <= pend_vld_nxt;
            ramp         <= ramp_nxt;
            target       <= target_nxt;
            active       <= active_nxt;
            out          <= out_nxt;
            period_start <= ps_nxt;
            busy         <= busy_nxt;
        end
    end

    // Shadow payload is only meaningful while pend_vld is set, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_duty <= pend_duty_nxt;
        pend_ramp <= pend_ramp_nxt;
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Testbench for pwm_seq_ctrl: directed scenarios followed by randomized
// traffic, all compared against a period-level behavioural model.
module tb_pwm_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] period_max = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [1:0]   wr_chan = '0;
    logic [W-1:0] wr_duty = '0;
    logic         wr_ramp = 1'b0;
    logic [3:0]   out;
    logic         period_start;
    logic         busy;

    pwm_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .period_max   (period_max),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_chan      (wr_chan),
        .wr_duty      (wr_duty),
        .wr_ramp      (wr_ramp),
        .out          (out),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a running flag, the position within the current period,
    // and per-channel shadow / committed / driven duties.
    bit m_on;
    int m_cnt;
    int m_pmax;
    bit m_pend[4];
    int m_pduty[4];
    bit m_pramp[4];
    int m_tgt[4];
    bit m_rmp[4];
    int m_act[4];

    int hi_cnt[4];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_cnt = 0; m_pmax = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_pduty[i] = 0; m_pramp[i] = 0;
            m_tgt[i] = 0; m_rmp[i] = 0; m_act[i] = 0;
        end
    endtask

    task automatic model_step(input bit e, input int pm, input bit wv,
                              input int ch, input int duty, input bit rmp);
        bit acc;
        int t;
        bit r;
        acc = wv && !m_pend[ch];
        if (!m_on) begin
            for (int i = 0; i < 4; i++)
                if (m_pend[i]) begin
                    m_act[i] = m_pduty[i]; m_tgt[i] = m_pduty[i];
                    m_rmp[i] = 0; m_pend[i] = 0;
                end
            if (e) begin m_on = 1; m_cnt = 0; m_pmax = pm; end
        end else if (m_cnt == m_pmax) begin
            for (int i = 0; i < 4; i++) begin
                t = m_pend[i] ? m_pduty[i] : m_tgt[i];
                r = m_pend[i] ? m_pramp[i] : m_rmp[i];
                m_tgt[i] = t; m_rmp[i] = r; m_pend[i] = 0;
                if (!r) m_act[i] = t;
                else if (m_act[i] < t) m_act[i] = m_act[i] + 1;
                else if (m_act[i] > t) m_act[i] = m_act[i] - 1;
            end
            m_cnt = 0; m_pmax = pm; m_on = e;
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (acc) begin
            m_pend[ch] = 1; m_pduty[ch] = duty; m_pramp[ch] = rmp;
        end
    endtask

    task automatic check_outputs();
        int eo;
        int eb;
        eo = 0; eb = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_on && (m_cnt < m_act[i])) eo = eo | (1 << i);
            if (m_act[i] != m_tgt[i]) eb = 1;
        end
        chk("out", int'(out), eo);
        chk("period_start", int'(period_start), int'(m_on && m_cnt == 0));
        chk("busy", int'(busy), eb);
    endtask

    // One clock: starts and ends at a falling edge. Outputs seen on entry are
    // tallied into hi_cnt, inputs apply to the coming rising edge.
    task automatic cycle(input bit e, input int pm, input bit wv,
                         input int ch, input int duty, input bit rmp);
        for (int i = 0; i < 4; i++) hi_cnt[i] += int'(out[i]);
        en = e; period_max = W'(pm); wr_valid = wv;
        wr_chan = 2'(ch); wr_duty = W'(duty); wr_ramp = rmp;
        #1;
        chk("wr_ready", int'(wr_ready), int'(!m_pend[ch]));
        model_step(e, pm, wv, ch, duty, rmp);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clr_hi();
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    endtask

    // Ten cycles at period_max=9, optionally writing at the third cycle.
    task automatic run_period(input bit wv, input int ch, input int duty, input bit rmp);
        clr_hi();
        for (int k = 0; k < 10; k++) cycle(1, 9, wv && (k == 2), ch, duty, rmp);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        en = 1'b0; wr_valid = 1'b0;
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rpm;
        bit re;
        model_reset();
        clr_hi();
        @(negedge clk);
        do_reset();

        // Step update: duty 3 written while idle, then 7 written at cnt=4.
        cycle(0, 9, 1, 0, 3, 0);
        cycle(0, 9, 0, 0, 0, 0);
        cycle(1, 9, 0, 0, 0, 0);
        clr_hi();
        for (int k = 0; k < 10; k++) cycle(1, 9, k == 4, 0, 7, 0);
        chk("step_first_period", hi_cnt[0], 3);
        clr_hi();
        for (int k = 0; k < 10; k++) cycle(1, 9, 0, 0, 0, 0);
        chk("step_second_period", hi_cnt[0], 7);

        // Ramp on ch1 from 2 to 5.
        run_period(1, 1, 2, 0);
        run_period(1, 1, 5, 1);
        chk("ramp_start", hi_cnt[1], 2);
        run_period(0, 0, 0, 0);
        chk("ramp_p1", hi_cnt[1], 3);
        run_period(0, 0, 0, 0);
        chk("ramp_p2", hi_cnt[1], 4);
        run_period(0, 0, 0, 0);
        chk("ramp_p3", hi_cnt[1], 5);
        run_period(0, 0, 0, 0);
        chk("ramp_hold", hi_cnt[1], 5);

        // Duty above period_max gives a constant-high channel.
        run_period(1, 2, 12, 0);
        run_period(0, 0, 0, 0);
        chk("duty_over_pmax", hi_cnt[2], 10);
        chk("ch0_kept", hi_cnt[0], 7);

        // Asynchronous reset mid-run with a channel high.
        chk("pre_reset_out2", int'(out[2]), 1);
        do_reset();
        cycle(0, 9, 1, 3, 4, 0);
        cycle(0, 9, 0, 0, 0, 0);

        // period_max = 0: every cycle is a boundary.
        cycle(0, 0, 1, 1, 1, 0);
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, 0, 0, 0);
        chk("pmax0_period_start", int'(period_start), 1);
        cycle(0, 0, 0, 0, 0, 0);

        // Drain: en drops at cnt=3, period finishes, then idle.
        cycle(1, 9, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) cycle(k < 3, 9, 0, 0, 0, 0);
        chk("drain_idle_out", int'(out), 0);
        chk("drain_idle_ps", int'(period_start), 0);

        // Drain aborted: en low for cnt 3..5, counter keeps running.
        cycle(1, 9, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) cycle(!(k >= 3 && k < 6), 9, 0, 0, 0, 0);
        chk("rerun_period_start", int'(period_start), 1);

        // Randomized traffic.
        rpm = 9;
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            if ($urandom_range(63) == 0) rpm = int'($urandom_range(12));
            re = ($urandom_range(15) != 0);
            cycle(re, rpm, $urandom_range(2) == 0, int'($urandom_range(3)),
                  int'($urandom_range(15)), $urandom_range(1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
